nano_dmem_arbiter: RTL
======================

Name: nano_dmem_arbiter

Overview:
- Shares the single-port 256x8 data memory between two requesters: the nanoRisk core load/store path (LW/SW) and a host loader/debug port that fills or inspects data memory.
- Round-robin arbitration with a host burst-lock mode and absolute host priority while the core is halted (Done).
- Sits between the core's LW/SW unit, the host interface and the synchronous data RAM.

Parameters:
- ADDR_W, 8, data memory address width (256 entries)
- DATA_W, 8, data word width
- CNT_W, 8, width of the saturating contention counter

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- core_halted  in  1  core Done flag; while 1, host has absolute priority
- c_req  in  1  core access request, held until c_gnt
- c_we  in  1  core write enable (1 = SW, 0 = LW)
- c_addr  in  ADDR_W  core address
- c_wdata  in  DATA_W  core store data
- c_gnt  out  1  core access accepted this cycle
- c_rvalid  out  1  core read data valid
- c_rdata  out  DATA_W  core read data
- h_req  in  1  host access request, held until h_gnt
- h_we  in  1  host write enable
- h_lock  in  1  host requests a locked burst
- h_addr  in  ADDR_W  host address
- h_wdata  in  DATA_W  host write data
- h_gnt  out  1  host access accepted this cycle
- h_rvalid  out  1  host read data valid
- h_rdata  out  DATA_W  host read data
- m_en  out  1  memory access strobe
- m_we  out  1  memory write enable
- m_addr  out  ADDR_W  memory address
- m_wdata  out  DATA_W  memory write data
- m_rdata  in  DATA_W  memory read data, valid 1 cycle after a read strobe
- contention  out  CNT_W  saturating count of cycles where both requested

Behaviour:
- Reset (rst=0, async): FSM=ARB, rr_last=HOST (core wins the first tie), rsel=NONE, contention=0, c_rvalid=h_rvalid=0. gnt, m_en and m_we are 0 because they are combinational from the requests and state.
- Grant is combinational in the request cycle. m_en=gnt_c|gnt_h. m_we, m_addr and m_wdata are muxed from the granted requester. At most one grant per cycle. Never both.
- A write completes in the grant cycle.
- A read grant sets rsel=granted requester. On the next cycle the arbiter asserts that requester's rvalid for exactly 1 cycle with rdata=m_rdata. The other requester's rvalid stays 0.
- Read latency is 1 cycle. Back-to-back grants are allowed every cycle, from either requester.
- c_rdata and h_rdata are driven from m_rdata continuously. They are meaningful only while the matching rvalid is high.
- Arbitration in ARB, in priority order:
  - core_halted=1: host only. c_gnt=0.
  - Only one requester active: that requester is granted.
  - Both active: grant the one not equal to rr_last.
  - rr_last updates to the granted requester on every grant.
- FSM states are ARB and HLOCK.
  - ARB -> HLOCK when h_gnt & h_lock.
  - HLOCK: host has exclusive grant. c_gnt=0 even if the host is idle.
  - HLOCK -> ARB on the first cycle where h_lock=0. That cycle is arbitrated normally.
  - Lock is dropped immediately if rst is asserted.
- contention increments on every cycle with c_req & h_req and saturates at 2^CNT_W-1. The counter also counts cycles where the core is blocked by HLOCK.
- Mid-operation reset: a pending rvalid is discarded. Requesters must re-issue requests.
- Simultaneous events:
  - core_halted rising during HLOCK keeps HLOCK.
  - core_halted falling does not reset rr_last.
- Address and data are passed through unmodified. No wrap logic is needed, because 8-bit addresses wrap naturally.

Decomposition:
- Shared package nano_pkg:
  - ADDR_W and DATA_W constants
  - requester enum {REQ_CORE, REQ_HOST, REQ_NONE}
  - FSM state enum {ST_ARB, ST_HLOCK}
- One natural sub-module: nano_rr_arb2. It is a 2-way round-robin picker holding rr_last, with inputs req[1:0] and mask, and outputs one-hot gnt.
- The lock FSM, read-return pipeline and counter stay in the top module.

Test Plan:
- Reset then core-only read of addr 0x05 with memory holding 0x9A -> c_gnt same cycle, c_rvalid=1 and c_rdata=0x9A next cycle, h_rvalid=0, contention=0.
- c_req and h_req held together for 4 cycles (reads) -> grant order core, host, core, host; contention=4; each rvalid follows its grant by 1 cycle.
- Host h_lock=1 writes 0x10..0x13 with 0xA0..0xA3 while c_req=1 -> h_gnt on 4 consecutive cycles, c_gnt=0 throughout. Then h_lock=0 with the host idle -> c_gnt next cycle; memory readback shows 0xA0..0xA3.
- core_halted=1, both requesting for 3 cycles -> only h_gnt asserted; core_halted=0 -> core granted on the next tie.
- Assert rst=0 in the cycle after a host read grant -> h_rvalid stays 0, FSM=ARB, contention=0; after release, the first tie goes to the core.
- 300 cycles of both requesting -> contention saturates at 255 and never wraps.

Source files
------------

// File: rtl/nano_pkg.sv
// Shared types and constants for the nanoRisk data-memory arbiter.
package nano_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;

  // Requester identity, also used as the read-return selector
  typedef enum logic [1:0] {
    REQ_CORE = 2'd0,
    REQ_HOST = 2'd1,
    REQ_NONE = 2'd2
  } req_e;

  // Arbiter FSM
  typedef enum logic {
    ST_ARB   = 1'b0,
    ST_HLOCK = 1'b1
  } state_e;

endpackage

// File: rtl/nano_rr_arb2.sv
// Two-way round-robin picker. Bit 0 is the core, bit 1 the host.
// A set mask bit removes that requester from arbitration this cycle.
module nano_rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic [1:0] mask,
  output logic [1:0] gnt
);
  import nano_pkg::*;

  req_e       last_q;
  req_e       last_d;
  logic [1:0] elig;

  assign elig = req & ~mask;

  // Pick a winner; on a tie the requester that did not win last time goes
  always_comb begin
    gnt    = 2'b00;
    last_d = last_q;
    case (elig)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last_q == REQ_HOST) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
    if (gnt[0]) begin
      last_d = REQ_CORE;
    end else if (gnt[1]) begin
      last_d = REQ_HOST;
    end
  end

  // Last winner register; reset to host so the core wins the first tie
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_q <= REQ_HOST;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/nano_dmem_arbiter.sv
// Shares the single-port data RAM between the core LW/SW path and the
// host loader/debug port.
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   ST_ARB   | normal round-robin between core and host
//   ST_HLOCK | host locked burst; core masked while h_lock stays high
module nano_dmem_arbiter #(
  parameter int ADDR_W = nano_pkg::ADDR_W,
  parameter int DATA_W = nano_pkg::DATA_W,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_halted,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_gnt,
  output logic              c_rvalid,
  output logic [DATA_W-1:0] c_rdata,
  input  logic              h_req,
  input  logic              h_we,
  input  logic              h_lock,
  input  logic [ADDR_W-1:0] h_addr,
  input  logic [DATA_W-1:0] h_wdata,
  output logic              h_gnt,
  output logic              h_rvalid,
  output logic [DATA_W-1:0] h_rdata,
  output logic              m_en,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  output logic [CNT_W-1:0]  contention
);
  import nano_pkg::*;

  state_e           state_q;
  state_e           state_d;
  req_e             rsel_q;
  req_e             rsel_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  logic       lock_active;
  logic [1:0] req;
  logic [1:0] mask;
  logic [1:0] gnt;

  // The exit cycle of a lock (h_lock low) is arbitrated normally
  assign lock_active = (state_q == ST_HLOCK) && h_lock;
  assign req         = {h_req, c_req};
  assign mask        = {1'b0, core_halted | lock_active};

  nano_rr_arb2 u_rr (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .mask (mask),
    .gnt  (gnt)
  );

  assign c_gnt   = gnt[0];
  assign h_gnt   = gnt[1];
  assign m_en    = c_gnt | h_gnt;
  assign m_we    = h_gnt ? h_we : (c_gnt & c_we);
  assign m_addr  = h_gnt ? h_addr : c_addr;
  assign m_wdata = h_gnt ? h_wdata : c_wdata;

  assign c_rdata    = m_rdata;
  assign h_rdata    = m_rdata;
  assign c_rvalid   = (rsel_q == REQ_CORE);
  assign h_rvalid   = (rsel_q == REQ_HOST);
  assign contention = cnt_q;

  // Lock FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ARB:   if (h_gnt && h_lock) state_d = ST_HLOCK;
      ST_HLOCK: if (!h_lock) state_d = ST_ARB;
      default:  state_d = ST_ARB;
    endcase
  end

  // Read-return owner for next cycle and contention counter update
  always_comb begin
    rsel_d = REQ_NONE;
    if (c_gnt && !c_we) begin
      rsel_d = REQ_CORE;
    end else if (h_gnt && !h_we) begin
      rsel_d = REQ_HOST;
    end
    cnt_d = cnt_q;
    // Core is waiting on the host: either both requesting or host holds the lock
    if (c_req && (h_req || lock_active) && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State, read-return and counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_ARB;
      rsel_q  <= REQ_NONE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rsel_q  <= rsel_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
